prio_arbiter: RTL and testbench

Parametrised, registered N-way priority arbiter with selectable fixed-priority or round-robin mode, grant hold until release, and a watchdog that force-releases grants held too long. It generalises the team's 4-bit combinational priority encoder into a sequential resource arbiter for shared-bus and shared-memory ports. The default fixed-priority decode matches the existing encoder: highest set index wins.

---
 rtl/arb_pkg.sv | 12 +
 rtl/prio_pick.sv | 41 ++++
 rtl/prio_arbiter.sv | 115 +++++++++++
 tb/tb_prio_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the priority arbiter and its picker.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational wrapping highest-first search; with start=N-1 (or fixed mode)
// it reduces to the plain "highest set index wins" priority encoder.
module prio_pick
    import arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin : search
        int   base;
        int   pos;
        logic found;

        idx   = '0;
        any   = |req;
        found = 1'b0;
        base  = N - 1;
        pos   = 0;

        // Out-of-range pointers (non power-of-two N) fall back to the top index.
        if (mode == MODE_RR && int'(start) < N) begin
            base = int'(start);
        end

        for (int k = 0; k < N; k++) begin
            pos = (base - k + N) % N;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: fixed or round-robin pick, grant held until done,
// and a watchdog that force-releases grants held for MAX_HOLD cycles.
module prio_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int W        = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid,
    output logic         timeout
);

    localparam int              CW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic            WD_EN   = (MAX_HOLD > 0);
    localparam logic [CW-1:0]   CNT_EXP = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [CW-1:0]   CNT_TOP = '1;
    localparam logic [N-1:0]    ONE_HOT = N'(1);
    localparam logic [W-1:0]    PTR_TOP = W'(N - 1);

    state_t         state_q;
    logic [N-1:0]   gnt_q;
    logic [W-1:0]   idx_q;
    logic           timeout_q;
    logic [W-1:0]   ptr_q;
    logic [CW-1:0]  cnt_q;

    logic [W-1:0]   pick_idx;
    logic           pick_any;
    logic [N-1:0]   gnt_d;
    logic [W-1:0]   ptr_d;
    logic [CW-1:0]  cnt_d;
    logic           wd_expire;
    logic           release_w;

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (req),
        .start (ptr_q),
        .mode  (mode),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        gnt_d     = ONE_HOT << pick_idx;
        ptr_d     = (pick_idx == '0) ? PTR_TOP : pick_idx - W'(1);
        cnt_d     = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CW'(1);
        wd_expire = WD_EN && (state_q == GRANT) && (cnt_q == CNT_EXP);
        release_w = (state_q == GRANT) && (done || wd_expire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            timeout_q <= 1'b0;
            ptr_q     <= PTR_TOP;
            cnt_q     <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q <= GRANT;
                        gnt_q   <= gnt_d;
                        idx_q   <= pick_idx;
                        ptr_q   <= ptr_d;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (release_w) begin
                        // done wins over a coincident expiry, so no pulse then.
                        timeout_q <= wd_expire && !done;
                        cnt_q     <= '0;
                        if (pick_any) begin
                            gnt_q <= gnt_d;
                            idx_q <= pick_idx;
                            ptr_q <= ptr_d;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (N=4, MAX_HOLD=4) with a cycle-level
// reference model and hand-computed spot checks.
module tb_prio_arbiter;

    localparam int N        = 4;
    localparam int W        = 2;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic         done;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    int total = 0;
    int bad   = 0;

    prio_arbiter #(
        .N        (N),
        .W        (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the resource, for how many cycles so far,
    // and where the round-robin search resumes.
    logic         m_valid;
    int           m_idx;
    int           m_ptr;
    int           m_held;
    logic         m_timeout;

    function automatic int winner(input logic [N-1:0] r, input logic md, input int ptr);
        int start;
        int p;
        start = md ? ptr : N - 1;
        for (int k = 0; k < N; k++) begin
            p = (start - k + N) % N;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_idx     <= 0;
            m_ptr     <= N - 1;
            m_held    <= 0;
            m_timeout <= 1'b0;
        end else begin : model_step
            int  w;
            bit  expired;
            bit  rel;
            w       = winner(req, mode, m_ptr);
            expired = m_valid && (m_held == MAX_HOLD);
            rel     = m_valid && (done || expired);
            m_timeout <= expired && !done;
            if ((!m_valid || rel) && w >= 0) begin
                m_valid <= 1'b1;
                m_idx   <= w;
                m_held  <= 1;
                m_ptr   <= (w + N - 1) % N;
            end else if (rel) begin
                m_valid <= 1'b0;
                m_held  <= 0;
            end else if (m_valid) begin
                m_held  <= m_held + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_valid", 32'(gnt_valid), 32'(m_valid));
            check("model_gnt", 32'(gnt), m_valid ? (32'd1 << m_idx) : 32'd0);
            check("model_timeout", 32'(timeout), 32'(m_timeout));
            if (m_valid) check("model_idx", 32'(gnt_idx), 32'(m_idx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        mode = 1'b0;
        done = 1'b0;
        do_reset();
        check("reset_valid", 32'(gnt_valid), 32'd0);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);

        // Fixed priority, then back-to-back handoff, then drain to idle.
        req = 4'b0110;
        tick();
        check("fix_gnt", 32'(gnt), 32'h4);
        check("fix_idx", 32'(gnt_idx), 32'd2);
        req  = 4'b0010;
        done = 1'b1;
        tick();
        check("fix_handoff_gnt", 32'(gnt), 32'h2);
        check("fix_handoff_valid", 32'(gnt_valid), 32'd1);
        req = 4'b0000;
        tick();
        check("fix_release_valid", 32'(gnt_valid), 32'd0);
        done = 1'b0;
        tick();
        check("idle_stays", 32'(gnt_valid), 32'd0);

        // Round-robin fairness from the reset pointer.
        do_reset();
        mode = 1'b1;
        req  = 4'b1111;
        tick();
        check("rr_0", 32'(gnt_idx), 32'd3);
        done = 1'b1;
        tick();
        check("rr_1", 32'(gnt_idx), 32'd2);
        tick();
        check("rr_2", 32'(gnt_idx), 32'd1);
        tick();
        check("rr_3", 32'(gnt_idx), 32'd0);
        tick();
        check("rr_4", 32'(gnt_idx), 32'd3);
        done = 1'b0;

        // Asynchronous reset in the middle of a grant.
        #2 rst = 1'b1;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_valid", 32'(gnt_valid), 32'd0);
        tick();
        rst  = 1'b0;
        mode = 1'b0;
        req  = '0;

        // Dropping req does not release the grant.
        do_reset();
        req = 4'b0010;
        tick();
        check("hold_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_drop", 32'(gnt), 32'h2);
        end
        done = 1'b1;
        tick();
        check("hold_release", 32'(gnt_valid), 32'd0);
        done = 1'b0;

        // Watchdog forced release with re-grant.
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wd_held", 32'(gnt), 32'h8);
            check("wd_no_pulse", 32'(timeout), 32'd0);
        end
        tick();
        check("wd_pulse", 32'(timeout), 32'd1);
        check("wd_regrant", 32'(gnt_idx), 32'd3);
        check("wd_regrant_valid", 32'(gnt_valid), 32'd1);
        tick();
        check("wd_pulse_end", 32'(timeout), 32'd0);

        // done on the last allowed cycle suppresses the pulse.
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        done = 1'b1;
        tick();
        check("wd_done_no_pulse", 32'(timeout), 32'd0);
        check("wd_done_regrant", 32'(gnt), 32'h8);
        done = 1'b0;

        // Mode change takes effect only at the next arbitration.
        do_reset();
        mode = 1'b0;
        req  = 4'b0011;
        tick();
        check("ms_fixed", 32'(gnt_idx), 32'd1);
        mode = 1'b1;
        tick();
        check("ms_unchanged", 32'(gnt_idx), 32'd1);
        done = 1'b1;
        tick();
        check("ms_rr_pick", 32'(gnt_idx), 32'd0);
        done = 1'b0;
        req  = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
